// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi BER test controller: FSM states and PRBS constants.
package viterbi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StFlush,
    StDrain,
    StDone
  } state_e;

  // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: taps on bits 0,2,3,5.
  localparam logic [15:0] LfsrTaps        = 16'h002D;
  localparam logic [15:0] LfsrDefaultSeed = 16'hACE1;

endpackage

// File: rtl/viterbi_lfsr16.sv
// 16-bit PRBS generator; a zero seed is replaced by the default seed so the register never locks up.
module viterbi_lfsr16
  import viterbi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [15:0] seed_i,
  output logic        bit_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == 16'd0) ? LfsrDefaultSeed : seed_i;
    end else if (step_i) begin
      lfsr_d = {^(lfsr_q & LfsrTaps), lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 16'd0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/viterbi_ber_ctrl.sv
// Viterbi BER test controller: PRBS frame source, channel error injector and decoded-bit checker.
// Define VITERBI_BER_BURST_EN to add err_burst_i and inject multi-symbol error bursts.
module viterbi_ber_ctrl
  import viterbi_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned FLUSH_LEN = 8,
  parameter int unsigned DEC_LAT   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] seed_i,
  input  logic [7:0]  err_period_i,
  input  logic [1:0]  err_mask_i,
`ifdef VITERBI_BER_BURST_EN
  input  logic [3:0]  err_burst_i,
`endif
  input  logic        decoder_i,
  output logic        enable_encoder_o,
  output logic        encoder_bit_o,
  output logic [1:0]  err_inj_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] bit_err_ct_o,
  output logic [15:0] inj_ct_o
);

  localparam int unsigned MaxA   = (FRAME_LEN > FLUSH_LEN) ? FRAME_LEN : FLUSH_LEN;
  localparam int unsigned MaxLen = (MaxA > DEC_LAT) ? MaxA : DEC_LAT;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              accept, lfsr_load, lfsr_step, lfsr_bit;
  logic              en_q, en_d, bit_q, bit_d, vld_q, vld_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [1:0]        inj_q, inj_d;
  logic [7:0]        sym_q, sym_d;
  logic              event_hit;
  logic [15:0]       inj_ct_q, inj_ct_d, berr_q, berr_d;
  logic [DEC_LAT-1:0] dly_bit_q, dly_bit_d, dly_vld_q, dly_vld_d;
`ifdef VITERBI_BER_BURST_EN
  logic [3:0]        burst_q, burst_d;
`endif

  viterbi_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load_i(lfsr_load),
    .step_i(lfsr_step),
    .seed_i(seed_i),
    .bit_o (lfsr_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          accept    = 1'b1;
          lfsr_load = 1'b1;
          cnt_d     = '0;
          state_d   = StSend;
        end
      end
      StSend: begin
        lfsr_step = 1'b1;
        if (cnt_q == CntW'(FRAME_LEN - 1)) begin
          cnt_d   = '0;
          state_d = StFlush;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFlush: begin
        if (cnt_q == CntW'(FLUSH_LEN - 1)) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == CntW'(DEC_LAT - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs lag the state by one register stage; done lands FRAME+FLUSH+LAT+1 edges after start.
  always_comb begin
    en_d   = (state_q == StSend) || (state_q == StFlush);
    vld_d  = (state_q == StSend);
    bit_d  = vld_d & lfsr_bit;
    busy_d = (state_q != StIdle);
    done_d = (state_q == StDone);
  end

  // Injector works on the symbol the encoder registers from the strobe currently visible.
  always_comb begin
    sym_d     = sym_q;
    inj_d     = 2'b00;
    inj_ct_d  = inj_ct_q;
    event_hit = 1'b0;
`ifdef VITERBI_BER_BURST_EN
    burst_d   = burst_q;
`endif
    if (accept) begin
      sym_d    = 8'd0;
      inj_ct_d = 16'd0;
`ifdef VITERBI_BER_BURST_EN
      burst_d  = 4'd0;
`endif
    end else if (en_q) begin
      event_hit = (err_period_i != 8'd0) && (sym_q >= err_period_i - 8'd1);
      sym_d     = (event_hit || err_period_i == 8'd0) ? 8'd0 : sym_q + 8'd1;
      if (event_hit && err_mask_i != 2'b00) begin
        inj_d = err_mask_i;
        if (inj_ct_q != 16'hFFFF) begin
          inj_ct_d = inj_ct_q + 16'd1;
        end
`ifdef VITERBI_BER_BURST_EN
        burst_d = err_burst_i;
      end else if (burst_q != 4'd0) begin
        inj_d   = err_mask_i;
        burst_d = burst_q - 4'd1;
`endif
      end
    end
`ifdef VITERBI_BER_BURST_EN
    else begin
      burst_d = 4'd0;
    end
`endif
  end

  always_comb begin
    dly_bit_d = DEC_LAT'({dly_bit_q, bit_q});
    dly_vld_d = DEC_LAT'({dly_vld_q, vld_q});
    berr_d    = berr_q;
    if (accept) begin
      berr_d = 16'd0;
    end else if (dly_vld_q[DEC_LAT-1] && (decoder_i ^ dly_bit_q[DEC_LAT-1]) &&
                 berr_q != 16'hFFFF) begin
      berr_d = berr_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      bit_q     <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      inj_q     <= 2'b00;
      sym_q     <= 8'd0;
      inj_ct_q  <= 16'd0;
      berr_q    <= 16'd0;
      dly_bit_q <= '0;
      dly_vld_q <= '0;
`ifdef VITERBI_BER_BURST_EN
      burst_q   <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      bit_q     <= bit_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      inj_q     <= inj_d;
      sym_q     <= sym_d;
      inj_ct_q  <= inj_ct_d;
      berr_q    <= berr_d;
      dly_bit_q <= dly_bit_d;
      dly_vld_q <= dly_vld_d;
`ifdef VITERBI_BER_BURST_EN
      burst_q   <= burst_d;
`endif
    end
  end

  assign enable_encoder_o = en_q;
  assign encoder_bit_o    = bit_q;
  assign err_inj_o        = inj_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign bit_err_ct_o     = berr_q;
  assign inj_ct_o         = inj_ct_q;

endmodule

// File: tb/tb_viterbi_ber_ctrl.sv
// Self-checking bench for viterbi_ber_ctrl: time-indexed reference tables plus literal spot checks.
module tb_viterbi_ber_ctrl;

  localparam int FL   = 256;
  localparam int FLU  = 8;
  localparam int DL   = 32;
  localparam int TL   = FL + FLU;
  localparam int TOT  = FL + FLU + DL + 1;
  localparam int TMAX = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] seed_i;
  logic [7:0]  err_period_i;
  logic [1:0]  err_mask_i;
`ifdef VITERBI_BER_BURST_EN
  logic [3:0]  err_burst;
`endif
  logic        decoder_i;
  logic        enable_encoder_o, encoder_bit_o, busy_o, done_o;
  logic [1:0]  err_inj_o;
  logic [15:0] bit_err_ct_o, inj_ct_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  bit run_on = 1'b0;

  // Reference tables indexed by symbol number / cycles since the accepting edge.
  logic       prbs_m     [0:FL];
  logic       errk_m     [0:FL];
  logic [1:0] inj_m      [0:TL];
  int         exp_inj_m  [0:TMAX];
  int         exp_berr_m [0:TMAX];

  viterbi_ber_ctrl #(
    .FRAME_LEN(FL),
    .FLUSH_LEN(FLU),
    .DEC_LAT  (DL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .seed_i          (seed_i),
    .err_period_i    (err_period_i),
    .err_mask_i      (err_mask_i),
`ifdef VITERBI_BER_BURST_EN
    .err_burst_i     (err_burst),
`endif
    .decoder_i       (decoder_i),
    .enable_encoder_o(enable_encoder_o),
    .encoder_bit_o   (encoder_bit_o),
    .err_inj_o       (err_inj_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .bit_err_ct_o    (bit_err_ct_o),
    .inj_ct_o        (inj_ct_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // mode 0: decoder echoes the data bit, 1: always inverted, 2: inverted on every 7th bit.
  task automatic arm(input logic [15:0] seed, input int per, input logic [1:0] mask,
                     input int blen, input int mode);
    logic [15:0] s;
    s = (seed == 16'd0) ? 16'hACE1 : seed;
    prbs_m[0] = 1'b0;
    errk_m[0] = 1'b0;
    for (int k = 1; k <= FL; k++) begin
      prbs_m[k] = s[0];
      s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
      errk_m[k] = (mode == 1) || (mode == 2 && k % 7 == 0);
    end
    for (int k = 0; k <= TL; k++) inj_m[k] = 2'b00;
    for (int t = 0; t <= TMAX; t++) begin
      exp_inj_m[t]  = 0;
      exp_berr_m[t] = 0;
    end
    for (int k = 1; k <= TL; k++) begin
      if (per != 0 && k % per == 0 && mask != 2'b00) begin
        for (int j = k; j < k + blen && j <= TL; j++) inj_m[j] = mask;
        for (int t = k + 1; t <= TMAX; t++) exp_inj_m[t]++;
      end
    end
    for (int k = 1; k <= FL; k++) begin
      if (errk_m[k]) begin
        for (int t = k + DL + 1; t <= TMAX; t++) exp_berr_m[t]++;
      end
    end
    seed_i       = seed;
    err_period_i = 8'(per);
    err_mask_i   = mask;
`ifdef VITERBI_BER_BURST_EN
    err_burst    = 4'(blen - 1);
`endif
  endtask

  task automatic kick();
    start_i = 1'b1;
    t0      = cyc + 1;
    run_on  = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 400) begin
      @(posedge clk); #2;
      n++;
    end
    chk("done_latency", cyc - t0, TOT);
    repeat (3) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin : cmp
    int t, tc, k;
    if (!run_on) begin
      chk("idle_enable", enable_encoder_o, 0);
      chk("idle_enc_bit", encoder_bit_o, 0);
      chk("idle_err_inj", err_inj_o, 0);
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
      chk("idle_inj_ct", inj_ct_o, 0);
      chk("idle_bit_err_ct", bit_err_ct_o, 0);
      decoder_i = 1'($urandom);
    end else begin
      t = cyc - t0;
      if (t >= 0) begin
        tc = (t > TMAX) ? TMAX : t;
        chk("enable", enable_encoder_o, (t >= 1 && t <= TL) ? 1 : 0);
        chk("enc_bit", encoder_bit_o, (t >= 1 && t <= FL) ? int'(prbs_m[t]) : 0);
        chk("busy", busy_o, (t >= 1 && t <= TOT) ? 1 : 0);
        chk("done", done_o, (t == TOT) ? 1 : 0);
        chk("err_inj", err_inj_o, (t >= 2 && t <= TL + 1) ? int'(inj_m[t-1]) : 0);
        chk("inj_ct", inj_ct_o, exp_inj_m[tc]);
        chk("bit_err_ct", bit_err_ct_o, exp_berr_m[tc]);
      end
      k = t - DL;
      if (k >= 1 && k <= FL) decoder_i = prbs_m[k] ^ errk_m[k];
      else decoder_i = 1'($urandom);
    end
  end

  initial begin
    logic [5:0] v;
    rst          = 1'b0;
    start_i      = 1'b0;
    seed_i       = 16'd0;
    err_period_i = 8'd0;
    err_mask_i   = 2'b00;
`ifdef VITERBI_BER_BURST_EN
    err_burst    = 4'd0;
`endif
    decoder_i    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_inj_ct", inj_ct_o, 0);
    chk("rst_bit_err_ct", bit_err_ct_o, 0);
    rst = 1'b1;
    @(posedge clk); #2;

    arm(16'h1234, 0, 2'b00, 1, 0);
    kick();
    wait_done();
    chk("loopback_bit_err", bit_err_ct_o, 0);
    chk("loopback_inj", inj_ct_o, 0);

    arm(16'hBEEF, 16, 2'b01, 1, 0);
    kick();
    wait_done();
    chk("period16_inj", inj_ct_o, 16);
    chk("period16_bit_err", bit_err_ct_o, 0);

    arm(16'h0F0F, 0, 2'b00, 1, 1);
    kick();
    wait_done();
    chk("inverted_bit_err", bit_err_ct_o, 256);

    // Second start during SEND must leave timing and counts untouched.
    arm(16'h5A5A, 5, 2'b11, 1, 2);
    kick();
    repeat (48) @(posedge clk);
    #2;
    start_i = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
    wait_done();
    chk("every7th_bit_err", bit_err_ct_o, 36);
    chk("period5_inj", inj_ct_o, 52);

    arm(16'h7777, 3, 2'b00, 1, 0);
    kick();
    wait_done();
    chk("zero_mask_inj", inj_ct_o, 0);

    arm(16'h1111, 4, 2'b10, 1, 0);
    kick();
    repeat (100) @(posedge clk);
    #2;
    chk("mid_frame_busy", busy_o, 1);
    rst    = 1'b0;
    run_on = 1'b0;
    #1;
    chk("async_rst_enable", enable_encoder_o, 0);
    chk("async_rst_busy", busy_o, 0);
    chk("async_rst_inj_ct", inj_ct_o, 0);
    @(posedge clk); #2;
    chk("rst_next_busy", busy_o, 0);
    rst = 1'b1;
    @(posedge clk); #2;

    arm(16'h0000, 0, 2'b00, 1, 0);
    kick();
    v = 6'd0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #2;
      v = {v[4:0], encoder_bit_o};
    end
    chk("ace1_first_bits", v, 6'b100001);
    wait_done();

`ifdef VITERBI_BER_BURST_EN
    arm(16'hC0DE, 64, 2'b10, 4, 0);
    kick();
    wait_done();
    chk("burst_inj", inj_ct_o, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
